// File: rtl/task_1_answer_framer_pkg.sv
// Shared types and constants for the task_1 answer framer.
//   state_t      : framer FSM states; the output states name the byte on o_tx_data
//   SOF_DEFAULT  : default start-of-frame byte
//   SIZE_W       : width of the packet length / byte counter
package task_1_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    HDR,
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM
  } state_t;

  localparam logic [7:0]  SOF_DEFAULT = 8'hA5;
  localparam int unsigned SIZE_W      = 12;

endpackage

// File: rtl/task_1_answer_framer_if.sv
// Framed byte stream from the answer framer toward the UART transmitter.
//   o_tx_data  : framed byte
//   o_tx_valid : o_tx_data valid
//   o_tx_last  : set with the checksum byte
//   i_tx_ready : UART side accepts the byte
// master = framer side, slave = UART side.
interface task_1_answer_framer_if;

  logic [7:0] o_tx_data;
  logic       o_tx_valid;
  logic       o_tx_last;
  logic       i_tx_ready;

  modport master (
    output o_tx_data,
    output o_tx_valid,
    output o_tx_last,
    input  i_tx_ready
  );

  modport slave (
    input  o_tx_data,
    input  o_tx_valid,
    input  o_tx_last,
    output i_tx_ready
  );

endinterface

// File: rtl/task_1_answer_framer_answer_buffer.sv
// Payload buffer: simple dual-port RAM, DEPTH x 8.
//   i_clk          : clock
//   i_we/i_waddr/i_wdata : write port
//   i_raddr        : read address
//   o_rdata        : registered read data (mem[i_raddr] one cycle later)
// Contents are not reset.
module answer_buffer #(
  parameter int unsigned DEPTH = 2048,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/task_1_answer_framer.sv
// Answer framer: buffers one complete gray answer packet, then sends it as
// SOF, 12-bit length (hi, lo), payload, XOR checksum.
//   i_clk, i_rst            : clock, async active-low reset
//   i_tanswer_ready/_data/_data_last, i_packet_size_in_bytes : answer input
//   o_tmanager_ready        : framer accepts an answer byte
//   tx                      : framed output stream (master side)
//   o_len_err               : one-cycle pulse, received count != announced size
//   o_overflow              : sticky, payload byte dropped (count > DEPTH)
module task_1_answer_framer
  import task_1_pkg::*;
#(
  parameter int unsigned DEPTH = 2048,
  parameter logic [7:0]  SOF   = SOF_DEFAULT
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_tanswer_ready,
  input  logic [7:0]             i_tanswer_data,
  input  logic                   i_tanswer_data_last,
  input  logic [SIZE_W-1:0]      i_packet_size_in_bytes,
  output logic                   o_tmanager_ready,
  output logic                   o_len_err,
  output logic                   o_overflow,
  task_1_answer_framer_if.master tx
);

  localparam int unsigned AW = $clog2(DEPTH);
  // Largest length field; a 4096-deep buffer is limited by the saturating counter.
  localparam logic [SIZE_W-1:0] LEN_CAP = (DEPTH >= 4096) ? '1 : SIZE_W'(DEPTH);

  state_t            r_state, w_state_nxt;
  logic [SIZE_W-1:0] r_cnt, w_cnt_nxt;
  logic [SIZE_W-1:0] r_size, w_size_nxt;
  logic [SIZE_W-1:0] r_rd_ptr, w_rd_ptr_nxt;
  logic [7:0]        r_csum, w_csum_nxt;
  logic [7:0]        r_tx_data, w_tx_data_nxt;
  logic              r_tx_valid, w_tx_valid_nxt;
  logic              r_tx_last, w_tx_last_nxt;
  logic              r_ready, w_ready_nxt;
  logic              r_len_err, w_len_err_nxt;
  logic              r_overflow, w_overflow_nxt;

  logic              w_in_xfer;
  logic              w_out_xfer;
  logic              w_we;
  logic [AW-1:0]     w_waddr;
  logic [AW-1:0]     w_raddr;
  logic [7:0]        w_rdata;
  logic [SIZE_W-1:0] w_len;
  logic [SIZE_W-1:0] w_cnt_inc;
  logic              w_store;

  assign w_in_xfer  = i_tanswer_ready && r_ready;
  assign w_out_xfer = r_tx_valid && tx.i_tx_ready;
  assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  assign w_len      = (r_cnt > LEN_CAP) ? LEN_CAP : r_cnt;
  assign w_store    = (DEPTH >= 4096) || (32'(r_cnt) < DEPTH);

  // The read address follows the next pointer so that the RAM output always
  // holds mem[r_rd_ptr]: the next payload byte is ready on every transfer.
  assign w_raddr = w_rd_ptr_nxt[AW-1:0];

  answer_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (i_tanswer_data),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_size     <= '0;
      r_rd_ptr   <= '0;
      r_csum     <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_tx_last  <= 1'b0;
      r_ready    <= 1'b1;
      r_len_err  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_size     <= w_size_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_csum     <= w_csum_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_tx_last  <= w_tx_last_nxt;
      r_ready    <= w_ready_nxt;
      r_len_err  <= w_len_err_nxt;
      r_overflow <= w_overflow_nxt;
    end
  end

  // Registered outputs are loaded with the byte of the state being entered.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_size_nxt     = r_size;
    w_rd_ptr_nxt   = r_rd_ptr;
    w_csum_nxt     = r_csum;
    w_tx_data_nxt  = r_tx_data;
    w_tx_valid_nxt = r_tx_valid;
    w_tx_last_nxt  = r_tx_last;
    w_ready_nxt    = r_ready;
    w_len_err_nxt  = 1'b0;
    w_overflow_nxt = r_overflow;
    w_we           = 1'b0;
    w_waddr        = r_cnt[AW-1:0];

    case (r_state)
      IDLE: begin
        w_rd_ptr_nxt = '0;
        if (w_in_xfer) begin
          w_we           = 1'b1;
          w_waddr        = '0;
          w_cnt_nxt      = SIZE_W'(1);
          w_size_nxt     = i_packet_size_in_bytes;
          w_overflow_nxt = 1'b0;
          w_csum_nxt     = '0;
          if (i_tanswer_data_last) begin
            w_len_err_nxt  = (i_packet_size_in_bytes != SIZE_W'(1));
            w_state_nxt    = HDR;
            w_tx_valid_nxt = 1'b1;
            w_tx_data_nxt  = SOF;
            w_tx_last_nxt  = 1'b0;
            w_ready_nxt    = 1'b0;
          end else begin
            w_state_nxt = COLLECT;
          end
        end
      end

      COLLECT: begin
        w_rd_ptr_nxt = '0;
        if (w_in_xfer) begin
          if (w_store) begin
            w_we = 1'b1;
          end else begin
            w_overflow_nxt = 1'b1;
          end
          w_cnt_nxt = w_cnt_inc;
          if (i_tanswer_data_last) begin
            w_len_err_nxt  = (w_cnt_inc != r_size);
            w_state_nxt    = HDR;
            w_tx_valid_nxt = 1'b1;
            w_tx_data_nxt  = SOF;
            w_tx_last_nxt  = 1'b0;
            w_ready_nxt    = 1'b0;
          end
        end
      end

      HDR: begin
        if (w_out_xfer) begin
          w_state_nxt   = LEN_HI;
          w_tx_data_nxt = {4'h0, w_len[11:8]};
        end
      end

      LEN_HI: begin
        if (w_out_xfer) begin
          w_csum_nxt    = r_csum ^ r_tx_data;
          w_state_nxt   = LEN_LO;
          w_tx_data_nxt = w_len[7:0];
        end
      end

      LEN_LO: begin
        if (w_out_xfer) begin
          w_csum_nxt    = r_csum ^ r_tx_data;
          w_state_nxt   = DATA;
          w_tx_data_nxt = w_rdata;
          w_rd_ptr_nxt  = r_rd_ptr + 1'b1;
        end
      end

      DATA: begin
        if (w_out_xfer) begin
          w_csum_nxt = r_csum ^ r_tx_data;
          if (r_rd_ptr == w_len) begin
            w_state_nxt   = CSUM;
            w_tx_data_nxt = r_csum ^ r_tx_data;
            w_tx_last_nxt = 1'b1;
          end else begin
            w_tx_data_nxt = w_rdata;
            w_rd_ptr_nxt  = r_rd_ptr + 1'b1;
          end
        end
      end

      CSUM: begin
        if (w_out_xfer) begin
          w_state_nxt    = IDLE;
          w_tx_valid_nxt = 1'b0;
          w_tx_data_nxt  = '0;
          w_tx_last_nxt  = 1'b0;
          w_ready_nxt    = 1'b1;
          w_csum_nxt     = '0;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign o_tmanager_ready = r_ready;
  assign o_len_err        = r_len_err;
  assign o_overflow       = r_overflow;
  assign tx.o_tx_data     = r_tx_data;
  assign tx.o_tx_valid    = r_tx_valid;
  assign tx.o_tx_last     = r_tx_last;

endmodule

// File: tb/tb_task_1_answer_framer.sv
// Scoreboard bench for task_1_answer_framer: a 2048-deep instance (index 0)
// and an 8-deep instance (index 1) for the overflow case.
module tb_task_1_answer_framer;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0] data;
    logic       last;
    bit         gap;   // must follow the previous transfer with no bubble
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_v  [2];
  logic [7:0]  in_d  [2];
  logic        in_l  [2];
  logic [11:0] in_sz [2];
  logic        txr   [2];
  bit          tog   [2];
  logic        mready[2];
  logic        lerr  [2];
  logic        ovf   [2];
  logic        txv   [2];
  logic [7:0]  txd   [2];
  logic        txl   [2];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  exp_t q0[$];
  exp_t q1[$];

  task_1_answer_framer_if ifa ();
  task_1_answer_framer_if ifb ();

  assign ifa.i_tx_ready = txr[0];
  assign ifb.i_tx_ready = txr[1];
  assign txv[0] = ifa.o_tx_valid;
  assign txd[0] = ifa.o_tx_data;
  assign txl[0] = ifa.o_tx_last;
  assign txv[1] = ifb.o_tx_valid;
  assign txd[1] = ifb.o_tx_data;
  assign txl[1] = ifb.o_tx_last;

  task_1_answer_framer dut (
    .i_clk                  (clk),
    .i_rst                  (rst_n),
    .i_tanswer_ready        (in_v[0]),
    .i_tanswer_data         (in_d[0]),
    .i_tanswer_data_last    (in_l[0]),
    .i_packet_size_in_bytes (in_sz[0]),
    .o_tmanager_ready       (mready[0]),
    .o_len_err              (lerr[0]),
    .o_overflow             (ovf[0]),
    .tx                     (ifa)
  );

  task_1_answer_framer #(.DEPTH(8)) dut8 (
    .i_clk                  (clk),
    .i_rst                  (rst_n),
    .i_tanswer_ready        (in_v[1]),
    .i_tanswer_data         (in_d[1]),
    .i_tanswer_data_last    (in_l[1]),
    .i_packet_size_in_bytes (in_sz[1]),
    .o_tmanager_ready       (mready[1]),
    .o_len_err              (lerr[1]),
    .o_overflow             (ovf[1]),
    .tx                     (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  function automatic exp_t pop(input int d);
    if (d == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  task automatic flush_all();
    q0.delete();
    q1.delete();
  endtask

  // Hand-written frame: SOF entry never carries the gap check.
  task automatic push_bytes(input int d, input bq_t f);
    exp_t e;
    for (int i = 0; i < f.size(); i++) begin
      e.data = f[i];
      e.last = (i == f.size() - 1);
      e.gap  = (i != 0) && !tog[d];
      push(d, e);
    end
  endtask

  // Reference frame built from the payload and the buffer depth.
  task automatic push_frame(input int d, input bq_t p, input int depth);
    bq_t        f;
    int         len;
    logic [11:0] l12;
    logic [7:0]  cs;
    len = (p.size() < depth) ? p.size() : depth;
    l12 = 12'(len);
    cs  = {4'h0, l12[11:8]} ^ l12[7:0];
    f.push_back(8'hA5);
    f.push_back({4'h0, l12[11:8]});
    f.push_back(l12[7:0]);
    for (int i = 0; i < len; i++) begin
      f.push_back(p[i]);
      cs = cs ^ p[i];
    end
    f.push_back(cs);
    push_bytes(d, f);
  endtask

  task automatic send_pkt(input int d, input bq_t b, input int size, input logic exp_err);
    int t;
    for (int i = 0; i < b.size(); i++) begin
      @(negedge clk);
      in_v[d]  = 1'b1;
      in_d[d]  = b[i];
      in_l[d]  = (i == b.size() - 1);
      in_sz[d] = 12'(size);
      t = 0;
      while (!mready[d] && t < 1000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 1000) begin
        errors++;
        checks++;
        $display("FAIL input_timeout: got ready=0, expected ready=1 within 1000 cycles");
        in_v[d] = 1'b0;
        in_l[d] = 1'b0;
        return;
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_v[d] = 1'b0;
    in_l[d] = 1'b0;
    chk("len_err_after_last", 32'(lerr[d]), 32'(exp_err));
    chk("sof_valid_after_last", 32'(txv[d]), 32'd1);
    chk("sof_data_after_last", 32'(txd[d]), 32'hA5);
    @(negedge clk);
    chk("len_err_one_cycle", 32'(lerr[d]), 32'd0);
  endtask

  task automatic wait_done(input int d);
    int t;
    t = 0;
    while (qsize(d) != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (qsize(d) != 0) begin
      errors++;
      checks++;
      $display("FAIL frame_timeout: got %0d bytes outstanding, expected 0", qsize(d));
      flush_all();
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor: pops on every output transfer and checks stall stability,
  // back-pressure of the input while sending, and ready after the checksum.
  bit         stall    [2];
  logic [7:0] hold_d   [2];
  logic       hold_l   [2];
  bit         rdy_pend [2];
  int         last_cyc [2];

  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        stall[d]    = 1'b0;
        rdy_pend[d] = 1'b0;
      end else begin
        if (rdy_pend[d]) begin
          chk("ready_after_csum", 32'(mready[d]), 32'd1);
          rdy_pend[d] = 1'b0;
        end
        if (stall[d]) begin
          chk("stall_valid", 32'(txv[d]), 32'd1);
          chk("stall_data", 32'(txd[d]), 32'(hold_d[d]));
          chk("stall_last", 32'(txl[d]), 32'(hold_l[d]));
        end
        if (txv[d]) chk("ready_low_during_tx", 32'(mready[d]), 32'd0);
        if (txv[d] && txr[d]) begin
          if (qsize(d) == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_tx[%0d]: got byte 0x%0h, expected no transfer", d, txd[d]);
          end else begin
            e = pop(d);
            chk("tx_data", 32'(txd[d]), 32'(e.data));
            chk("tx_last", 32'(txl[d]), 32'(e.last));
            if (e.gap) chk("no_bubble", 32'(cyc), 32'(last_cyc[d] + 1));
            if (e.last) rdy_pend[d] = 1'b1;
          end
          last_cyc[d] = cyc;
        end
        stall[d]  = txv[d] && !txr[d];
        hold_d[d] = txd[d];
        hold_l[d] = txl[d];
      end
    end
  end

  // UART-side ready: held high, or toggled every cycle when tog is set.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (tog[d]) txr[d] = ~txr[d];
        else        txr[d] = 1'b1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1 ms");
    $fatal(1);
  end

  initial begin
    bq_t p;
    int  t;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_v[d] = 1'b0; in_d[d] = '0; in_l[d] = 1'b0; in_sz[d] = '0;
      txr[d] = 1'b1; tog[d] = 1'b0;
      stall[d] = 1'b0; rdy_pend[d] = 1'b0; last_cyc[d] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(mready[0]), 32'd1);
    chk("rst_valid", 32'(txv[0]), 32'd0);
    chk("rst_data", 32'(txd[0]), 32'h00);
    chk("rst_last", 32'(txl[0]), 32'd0);
    chk("rst_len_err", 32'(lerr[0]), 32'd0);
    chk("rst_overflow", 32'(ovf[0]), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Three-byte packet.
    p = '{8'h10, 8'h20, 8'h30};
    push_bytes(0, '{8'hA5, 8'h00, 8'h03, 8'h10, 8'h20, 8'h30, 8'h03});
    send_pkt(0, p, 3, 1'b0);
    wait_done(0);

    // First and last on one byte.
    p = '{8'hFF};
    push_bytes(0, '{8'hA5, 8'h00, 8'h01, 8'hFF, 8'hFE});
    send_pkt(0, p, 1, 1'b0);
    wait_done(0);

    // 300-byte ramp with the UART side stalling every other cycle.
    tog[0] = 1'b1;
    p.delete();
    for (int i = 0; i < 300; i++) p.push_back(8'(i));
    push_frame(0, p, 2048);
    send_pkt(0, p, 300, 1'b0);
    wait_done(0);
    tog[0] = 1'b0;
    repeat (2) @(negedge clk);

    // Four bytes announced as five.
    p = '{8'h01, 8'h02, 8'h03, 8'h04};
    push_bytes(0, '{8'hA5, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00});
    send_pkt(0, p, 5, 1'b1);
    wait_done(0);
    chk("no_overflow_depth2048", 32'(ovf[0]), 32'd0);

    // Ten bytes into the 8-deep instance: last two dropped.
    p.delete();
    for (int i = 0; i < 10; i++) p.push_back(8'(8'h31 + 8'(i * 7)));
    push_frame(1, p, 8);
    send_pkt(1, p, 10, 1'b0);
    wait_done(1);
    chk("overflow_sticky", 32'(ovf[1]), 32'd1);

    // Reset in the middle of the payload.
    p.delete();
    for (int i = 0; i < 20; i++) p.push_back(8'(8'hC0 ^ 8'(i)));
    push_frame(0, p, 2048);
    send_pkt(0, p, 20, 1'b0);
    t = 0;
    while (qsize(0) > 12 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("reached_data_before_reset", 32'(qsize(0) <= 12), 32'd1);
    #2;
    rst_n = 1'b0;
    flush_all();
    #1;
    chk("async_rst_valid", 32'(txv[0]), 32'd0);
    chk("async_rst_data", 32'(txd[0]), 32'h00);
    chk("async_rst_last", 32'(txl[0]), 32'd0);
    chk("async_rst_ready", 32'(mready[0]), 32'd1);
    chk("async_rst_overflow8", 32'(ovf[1]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two-byte packet after the reset.
    p = '{8'hAB, 8'hCD};
    push_bytes(0, '{8'hA5, 8'h00, 8'h02, 8'hAB, 8'hCD, 8'h64});
    send_pkt(0, p, 2, 1'b0);
    wait_done(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/task_1_answer_framer.md
# task_1_answer_framer

Downstream stage of the task_1 grayscale pipeline. Consumes the gray answer byte stream, its `last` marker and the announced packet size, and buffers one complete answer packet. Then emits it as a framed byte stream (start byte, 12-bit length, payload, XOR checksum) toward the UART transmitter. One packet in flight; the input is back-pressured while a frame is being sent.

## Interface
- `DEPTH`, 2048: payload buffer capacity in bytes (power of two, ≤ 4096).
- `SOF`, 8'hA5: start-of-frame byte.

- `i_clk` in 1: clock.
- `i_rst` in 1: reset, asynchronous, active-low.
- `i_tanswer_ready` in 1: answer byte valid from task_1.
- `i_tanswer_data` in 8: gray answer byte.
- `i_tanswer_data_last` in 1: marks the final answer byte of a packet.
- `i_packet_size_in_bytes` in 12: announced answer length; sampled with the first byte.
- `o_tmanager_ready` out 1: framer can accept an answer byte.
- `o_tx_data` out 8: framed output byte.
- `o_tx_valid` out 1: `o_tx_data` valid.
- `i_tx_ready` in 1: UART side accepts the byte.
- `o_tx_last` out 1: asserted with the checksum byte.
- `o_len_err` out 1: one-cycle pulse; received count ≠ announced size.
- `o_overflow` out 1: sticky; a payload byte was dropped (count > DEPTH). Cleared at the next packet's first byte.

## Operation
- Input transfer: a byte moves when `i_tanswer_ready && o_tmanager_ready`.
- Output transfer: a byte moves when `o_tx_valid && i_tx_ready`.
- States:
  - IDLE → COLLECT on the first input byte. Store it, set cnt=1, latch size.
  - COLLECT → HDR on the byte with last.
  - HDR (SOF) → LEN_HI (`{4'h0, cnt[11:8]}`) → LEN_LO (`cnt[7:0]`) → DATA (cnt bytes, address 0..cnt-1) → CSUM → IDLE.
  - Each output state advances only on an output transfer.
- A single byte carrying both first and last goes IDLE → HDR directly with cnt=1.
- `o_tmanager_ready` = 1 in IDLE and COLLECT, 0 in HDR..CSUM.
- cnt is 12 bits and saturates at 4095.
- Bytes with cnt ≥ DEPTH are not written and set `o_overflow`. The length field is min(cnt, DEPTH).
- Checksum = XOR of LEN_HI, LEN_LO and every emitted payload byte.
- `o_len_err` pulses in the cycle after last is accepted if cnt ≠ latched size. The frame is still sent.
- Reset (any state): async return to IDLE, cnt=0, checksum=0. Buffer contents are don't-care.

## Timing
- Reset values:
  - `o_tmanager_ready`=1
  - `o_tx_valid`=0
  - `o_tx_data`=8'h00
  - `o_tx_last`=0
  - `o_len_err`=0
  - `o_overflow`=0
- All outputs are registered.
- Last byte accepted in cycle n → `o_tx_valid`=1 with SOF in cycle n+1.
- With `i_tx_ready` held high, the frame streams at 1 byte/cycle: cnt+4 consecutive bytes, no bubbles. The buffer read is prefetched one byte ahead so that DATA→DATA and LEN_LO→DATA need no stall.
- While `o_tx_valid && !i_tx_ready`, `o_tx_data` and `o_tx_last` hold stable.
- After the CSUM transfer in cycle m, `o_tmanager_ready`=1 in cycle m+1.
- Input bytes presented while `o_tmanager_ready`=0 are not consumed. The upstream holds them.

## Structure
- Package `task_1_pkg`:
  - state enum (IDLE, COLLECT, HDR, LEN_HI, LEN_LO, DATA, CSUM)
  - `SOF` default constant
  - 12-bit size width constant
- Sub-module `answer_buffer`: simple dual-port RAM, DEPTH×8, one write port, registered read port (1-cycle latency).

## Test plan
- Packet 0x10,0x20,0x30, size=3, `i_tx_ready`=1 → A5 00 03 10 20 30 03. `o_tx_last` on the final byte, no `o_len_err`, 7 consecutive valid cycles.
- Single byte 0xFF with last, size=1 → A5 00 01 FF FE.
- 300-byte ramp (i & 0xFF), size=300, `i_tx_ready` toggling 1/0 each cycle → length bytes 01 2C and correct payload order. Each output byte is held stable during its stall, and `o_tmanager_ready`=0 throughout transmission.
- 4 bytes sent with size=5 → `o_len_err` pulse one cycle after last. Frame length field is 00 04.
- DEPTH=8 build, 10 bytes → `o_overflow`=1, length field 00 08, first 8 bytes emitted.
- Reset asserted during DATA → outputs go to reset values immediately. The next 2-byte packet frames correctly.
